// File: rtl/apb_fpu_regfile.sv
// apb_fpu_regfile: operand/op-select/flag registers and launch/capture sequencer for the FPU datapath.
// Define APB_FPU_IRQ_EN to build the completion interrupt; otherwise irq is tied low.
module apb_fpu_regfile #(
   parameter int OP_W = 4,
   parameter int RM_W = 3
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic [1:0]      register_addr,
   input  logic            write,
   input  logic            enable_reg,
   input  logic [31:0]     Wdata,
   input  logic            FPU_enable,
   output logic [31:0]     data_slave,
   output logic            data_valid,
   output logic [31:0]     fpu_a,
   output logic [31:0]     fpu_b,
   output logic [OP_W-1:0] fpu_op,
   output logic [RM_W-1:0] fpu_rm,
   output logic            fpu_start,
   input  logic [31:0]     fpu_result,
   input  logic [4:0]      fpu_flags,
   input  logic            fpu_done,
   output logic            irq
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [31:0] opsel, result;
   logic [5:0]  flags_lo;
   logic        flag_done, wr, acc, go, clr, capture;
   assign wr      = enable_reg & write;
   assign acc     = wr & (state != BUSY);
   assign go      = acc & (register_addr == 2'b10);
   assign clr     = wr & (register_addr == 2'b11);
   assign capture = (state == BUSY) & fpu_done;
   assign fpu_op  = opsel[OP_W-1:0];
   assign fpu_rm  = opsel[OP_W+RM_W-1:OP_W];
   always_comb begin
      state_nx   = go ? BUSY : capture ? DONE : state;
      data_slave = register_addr == 2'b00 ? result :
                   register_addr == 2'b01 ? fpu_b :
                   register_addr == 2'b10 ? opsel : {flag_done, 25'd0, flags_lo};
   end
   // capture is applied last so a same-cycle Flags clear loses to it
   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN) begin
         state      <= IDLE;
         fpu_a      <= '0;
         fpu_b      <= '0;
         opsel      <= '0;
         result     <= '0;
         flags_lo   <= '0;
         flag_done  <= 1'b0;
         data_valid <= 1'b0;
         fpu_start  <= 1'b0;
      end else begin
         state     <= state_nx;
         fpu_start <= go;
         if (acc && register_addr == 2'b00) fpu_a <= Wdata;
         if (acc && register_addr == 2'b01) fpu_b <= Wdata;
         if (go) opsel <= Wdata;
         if (clr) begin
            flags_lo  <= '0;
            flag_done <= 1'b0;
         end
         if (wr && state == BUSY && register_addr != 2'b11) flags_lo[5] <= 1'b1;
         if (go) begin
            flag_done  <= 1'b0;
            data_valid <= 1'b0;
         end
         if (capture) begin
            result        <= fpu_result;
            flags_lo[4:0] <= fpu_flags;
            flag_done     <= 1'b1;
            data_valid    <= 1'b1;
         end
      end
`ifdef APB_FPU_IRQ_EN
   logic irq_r;
   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN) irq_r <= 1'b0;
      else if (capture) irq_r <= 1'b1;
      else if ((FPU_enable && register_addr == 2'b00) || clr || go) irq_r <= 1'b0;
   assign irq = irq_r;
`else
   logic unused_rd;
   assign unused_rd = FPU_enable;
   assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_apb_fpu_regfile.sv
// tb_apb_fpu_regfile: directed scoreboard bench for apb_fpu_regfile.
// Expectations are queued as stimulus is driven and popped when the DUT output is sampled.
module tb_apb_fpu_regfile;
`ifdef APB_FPU_IRQ_EN
   localparam logic IRQ = 1'b1;
`else
   localparam logic IRQ = 1'b0;
`endif
   logic        CLK = 1'b0, RSTN = 1'b0;
   logic [1:0]  register_addr = '0;
   logic        write = 1'b0, enable_reg = 1'b0, FPU_enable = 1'b0, fpu_done = 1'b0;
   logic [31:0] Wdata = '0, fpu_result = '0;
   logic [4:0]  fpu_flags = '0;
   logic [31:0] data_slave, fpu_a, fpu_b;
   logic [3:0]  fpu_op;
   logic [2:0]  fpu_rm;
   logic        data_valid, fpu_start, irq;
   string       tag_q[$];
   logic [31:0] exp_q[$];
   int          n_cmp = 0, n_bad = 0;

   apb_fpu_regfile dut (
      .CLK(CLK), .RSTN(RSTN), .register_addr(register_addr), .write(write),
      .enable_reg(enable_reg), .Wdata(Wdata), .FPU_enable(FPU_enable),
      .data_slave(data_slave), .data_valid(data_valid), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_start(fpu_start), .fpu_result(fpu_result),
      .fpu_flags(fpu_flags), .fpu_done(fpu_done), .irq(irq)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic push(input string t, input logic [31:0] e);
      tag_q.push_back(t);
      exp_q.push_back(e);
   endtask

   task automatic pop(input logic [31:0] got);
      string       t;
      logic [31:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $error("FAIL sb_empty: observed %h with no queued expectation", got);
         return;
      end
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (got === e) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", t, got, e);
      end
   endtask

   task automatic sig(input string t, input logic [31:0] e, input logic [31:0] got);
      push(t, e);
      pop(got);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      register_addr = a; Wdata = d; write = 1'b1; enable_reg = 1'b1;
      @(posedge CLK); #1;
      write = 1'b0; enable_reg = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input string t, input logic [31:0] e);
      register_addr = a; FPU_enable = 1'b1;
      push(t, e);
      #2;
      pop(data_slave);
      @(posedge CLK); #1;
      FPU_enable = 1'b0;
   endtask

   task automatic done_pulse(input logic [31:0] r, input logic [4:0] f);
      fpu_result = r; fpu_flags = f; fpu_done = 1'b1;
      @(posedge CLK); #1;
      fpu_done = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1 RSTN = 1'b1;
      @(posedge CLK); #1;
      rd(2'b00, "rst_result", 32'h0);
      rd(2'b01, "rst_op2", 32'h0);
      rd(2'b10, "rst_opsel", 32'h0);
      rd(2'b11, "rst_flags", 32'h0);
      sig("rst_valid", 32'(0), 32'(data_valid));
      sig("rst_start", 32'(0), 32'(fpu_start));
      sig("rst_irq", 32'(0), 32'(irq));
      sig("rst_fpu_a", 32'h0, fpu_a);

      // basic launch
      wr(2'b00, 32'h3F800000);
      wr(2'b01, 32'h40000000);
      wr(2'b10, 32'h00000010);
      sig("start_pulse", 32'(1), 32'(fpu_start));
      sig("fpu_a", 32'h3F800000, fpu_a);
      sig("fpu_b", 32'h40000000, fpu_b);
      sig("fpu_op", 32'(0), 32'(fpu_op));
      sig("fpu_rm", 32'(1), 32'(fpu_rm));
      wr(2'b00, 32'h12345678);
      sig("start_single", 32'(0), 32'(fpu_start));
      sig("busy_op1_kept", 32'h3F800000, fpu_a);
      rd(2'b11, "busy_err_flag", 32'h00000020);
      wr(2'b11, 32'hFFFFFFFF);
      rd(2'b11, "flags_cleared", 32'h0);
      sig("valid_busy", 32'(0), 32'(data_valid));
      done_pulse(32'h40400000, 5'b00001);
      sig("valid_done", 32'(1), 32'(data_valid));
      sig("irq_done", 32'(IRQ), 32'(irq));
      rd(2'b11, "flags_done", 32'h80000001);
      sig("irq_after_flag_rd", 32'(IRQ), 32'(irq));
      rd(2'b00, "result", 32'h40400000);
      sig("irq_after_res_rd", 32'(0), 32'(irq));
      sig("valid_after_rd", 32'(1), 32'(data_valid));

      // done in the start cycle, with a simultaneous Flags clear
      wr(2'b10, 32'h00000023);
      sig("start2", 32'(1), 32'(fpu_start));
      sig("valid_cleared", 32'(0), 32'(data_valid));
      sig("fpu_op2", 32'(3), 32'(fpu_op));
      sig("fpu_rm2", 32'(2), 32'(fpu_rm));
      fpu_result = 32'hC0000000; fpu_flags = 5'b10100; fpu_done = 1'b1;
      register_addr = 2'b11; write = 1'b1; enable_reg = 1'b1;
      @(posedge CLK); #1;
      fpu_done = 1'b0; write = 1'b0; enable_reg = 1'b0;
      sig("valid_fast", 32'(1), 32'(data_valid));
      sig("start2_off", 32'(0), 32'(fpu_start));
      sig("irq_fast", 32'(IRQ), 32'(irq));
      rd(2'b11, "flags_capture_wins", 32'h80000014);
      rd(2'b00, "result_fast", 32'hC0000000);

      // done outside BUSY is ignored
      done_pulse(32'h11111111, 5'h1F);
      rd(2'b00, "ignored_result", 32'hC0000000);
      rd(2'b11, "ignored_flags", 32'h80000014);

      // reset mid-BUSY
      wr(2'b10, 32'h00000010);
      sig("start3", 32'(1), 32'(fpu_start));
      RSTN = 1'b0;
      register_addr = 2'b10;
      #2;
      sig("mid_rst_valid", 32'(0), 32'(data_valid));
      sig("mid_rst_start", 32'(0), 32'(fpu_start));
      sig("mid_rst_opsel", 32'h0, data_slave);
      sig("mid_rst_fpu_a", 32'h0, fpu_a);
      @(posedge CLK); #1;
      RSTN = 1'b1;
      done_pulse(32'hDEADBEEF, 5'h1F);
      sig("late_done_valid", 32'(0), 32'(data_valid));
      sig("late_done_irq", 32'(0), 32'(irq));
      rd(2'b00, "late_done_result", 32'h0);
      rd(2'b11, "late_done_flags", 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
